trigger_capture: RTL and testbench

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

---
 rtl/trigger_capture.sv | 121 ++++++++++++
 tb/tb_trigger_capture.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture.sv
// trigger_capture: accumulates trigger events into a sticky pending register
// and hands a snapshot of them to a consumer on request.
//
// Optional feature macro: TRIG_EDGE_DETECT_EN
//   defined   -> an event is a rising edge of trig_in (one event per held level)
//   undefined -> an event is every cycle trig_in is high
//
// Ports:
//   ep_clk       in   1      sole clock, rising edge
//   reset        in   1      synchronous, active-high reset
//   trig_in      in   WIDTH  trigger inputs from the producing logic
//   update_req   in   1      one-cycle request to snapshot pending triggers
//   snap_ack     in   1      consumer has read the snapshot
//   snap_data    out  WIDTH  captured trigger bits
//   snap_missed  out  8      events lost since the previous snapshot
//   snap_valid   out  1      snapshot held and unread
//   any_pending  out  1      OR of all pending bits (registered)
module trigger_capture #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             ep_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] trig_in,
  input  logic             update_req,
  input  logic             snap_ack,
  output logic [WIDTH-1:0] snap_data,
  output logic [7:0]       snap_missed,
  output logic             snap_valid,
  output logic             any_pending
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] pending, pending_nxt;
  logic [WIDTH-1:0] event_vec;
  logic [CNT_W-1:0] miss_cnt, miss_cnt_nxt, miss_cnt_inc;
  logic [WIDTH-1:0] snap_data_nxt;
  logic [CNT_W-1:0] snap_missed_nxt;
  logic             snap_valid_nxt;
  logic             miss;

  // Event source selection
`ifdef TRIG_EDGE_DETECT_EN
  logic [WIDTH-1:0] trig_in_d;

  always_ff @(posedge ep_clk) begin
    if (reset) begin
      trig_in_d <= '0;
    end else begin
      trig_in_d <= trig_in;
    end
  end

  assign event_vec = trig_in & ~trig_in_d;
`else
  assign event_vec = trig_in;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt       = state;
    pending_nxt     = pending | event_vec;
    snap_data_nxt   = snap_data;
    snap_missed_nxt = snap_missed;
    snap_valid_nxt  = snap_valid;

    // Misses are judged against the old pending value, so a capture edge
    // still counts a collision with a bit it is about to clear.
    miss         = |(event_vec & pending);
    miss_cnt_inc = (miss && (miss_cnt != CNT_MAX)) ? miss_cnt + CNT_W'(1) : miss_cnt;
    miss_cnt_nxt = miss_cnt_inc;

    case (state)
      IDLE: begin
        if (update_req) begin
          snap_data_nxt   = pending | event_vec;
          snap_missed_nxt = miss_cnt_inc;
          snap_valid_nxt  = 1'b1;
          pending_nxt     = '0;
          miss_cnt_nxt    = '0;
          state_nxt       = HOLD;
        end
      end
      HOLD: begin
        // update_req is ignored here; pending keeps accumulating
        if (snap_ack) begin
          snap_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge ep_clk) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      miss_cnt    <= '0;
      snap_data   <= '0;
      snap_missed <= '0;
      snap_valid  <= 1'b0;
      any_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      miss_cnt    <= miss_cnt_nxt;
      snap_data   <= snap_data_nxt;
      snap_missed <= snap_missed_nxt;
      snap_valid  <= snap_valid_nxt;
      any_pending <= |pending_nxt;
    end
  end

endmodule

// File: tb/tb_trigger_capture.sv
// Testbench for trigger_capture: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the capture rules.
module tb_trigger_capture;

  localparam int unsigned WIDTH = 16;

  logic             ep_clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] trig_in;
  logic             update_req;
  logic             snap_ack;
  logic [WIDTH-1:0] snap_data;
  logic [7:0]       snap_missed;
  logic             snap_valid;
  logic             any_pending;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [WIDTH-1:0] m_pend  = '0;
  logic [WIDTH-1:0] m_data  = '0;
  logic [WIDTH-1:0] m_prev  = '0;
  int               m_cnt    = 0;
  int               m_missed = 0;
  bit               m_hold   = 1'b0;
  bit               m_valid  = 1'b0;

  trigger_capture #(.WIDTH(WIDTH)) dut (
    .ep_clk      (ep_clk),
    .reset       (reset),
    .trig_in     (trig_in),
    .update_req  (update_req),
    .snap_ack    (snap_ack),
    .snap_data   (snap_data),
    .snap_missed (snap_missed),
    .snap_valid  (snap_valid),
    .any_pending (any_pending)
  );

  always #5 ep_clk = ~ep_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the capture rules for one edge to the model
  task automatic model_step(input logic [WIDTH-1:0] t, input bit u, input bit a, input bit r);
    logic [WIDTH-1:0] ev;
    int               lost;
`ifdef TRIG_EDGE_DETECT_EN
    ev = t & ~m_prev;
`else
    ev = t;
`endif
    if (r) begin
      m_pend = '0; m_data = '0; m_prev = '0;
      m_cnt = 0; m_missed = 0; m_hold = 1'b0; m_valid = 1'b0;
    end else begin
      lost = ((ev & m_pend) != '0) ? 1 : 0;
      if (!m_hold && u) begin
        m_data   = m_pend | ev;
        m_missed = (m_cnt + lost > 255) ? 255 : m_cnt + lost;
        m_cnt    = 0;
        m_pend   = '0;
        m_valid  = 1'b1;
        m_hold   = 1'b1;
      end else begin
        m_pend = m_pend | ev;
        m_cnt  = (m_cnt + lost > 255) ? 255 : m_cnt + lost;
        if (m_hold && a) begin
          m_valid = 1'b0;
          m_hold  = 1'b0;
        end
      end
      m_prev = t;
    end
  endtask

  // Drive one cycle, advance the model, then compare all outputs after the edge
  task automatic cycle(input logic [WIDTH-1:0] t, input bit u, input bit a, input bit r);
    trig_in    = t;
    update_req = u;
    snap_ack   = a;
    reset      = r;
    model_step(t, u, a, r);
    @(posedge ep_clk);
    #1;
    check_eq("snap_data",   32'(snap_data),   32'(m_data));
    check_eq("snap_missed", 32'(snap_missed), 32'(m_missed));
    check_eq("snap_valid",  32'(snap_valid),  32'(m_valid));
    check_eq("any_pending", 32'(any_pending), 32'(m_pend != '0));
  endtask

  initial begin
    trig_in = '0; update_req = 1'b0; snap_ack = 1'b0; reset = 1'b1;

    // Reset state, including update/ack/trig asserted alongside reset
    cycle(16'hFFFF, 1'b1, 1'b1, 1'b1);
    check_eq("rst_valid",   32'(snap_valid),  32'd0);
    check_eq("rst_data",    32'(snap_data),   32'd0);
    check_eq("rst_missed",  32'(snap_missed), 32'd0);
    check_eq("rst_pending", 32'(any_pending), 32'd0);

    // Two separated pulses, then capture
    cycle(16'h0001, 1'b0, 1'b0, 1'b0);
    check_eq("first_evt_pending", 32'(any_pending), 32'd1);
    cycle(16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(16'h0080, 1'b0, 1'b0, 1'b0);
    cycle(16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(16'h0000, 1'b1, 1'b0, 1'b0);
    check_eq("cap1_valid",  32'(snap_valid),  32'd1);
    check_eq("cap1_data",   32'(snap_data),   32'h0081);
    check_eq("cap1_missed", 32'(snap_missed), 32'd0);
    check_eq("cap1_pend",   32'(any_pending), 32'd0);

    // Event during HOLD is kept for the next snapshot
    cycle(16'h0004, 1'b0, 1'b0, 1'b0);
    check_eq("hold_stable", 32'(snap_data), 32'h0081);
    cycle(16'h0000, 1'b0, 1'b1, 1'b0);
    check_eq("ack_valid", 32'(snap_valid), 32'd0);
    cycle(16'h0000, 1'b0, 1'b1, 1'b0);
    cycle(16'h0000, 1'b1, 1'b0, 1'b0);
    check_eq("cap2_data",  32'(snap_data),  32'h0004);
    check_eq("cap2_valid", 32'(snap_valid), 32'd1);
    // update together with ack in HOLD: ack wins, no new capture
    cycle(16'h0010, 1'b1, 1'b1, 1'b0);
    check_eq("upd_ack_valid", 32'(snap_valid), 32'd0);
    check_eq("upd_ack_data",  32'(snap_data),  32'h0004);

    // Three pulses on bit 0 -> two misses
    cycle(16'h0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(16'h0001, 1'b0, 1'b0, 1'b0);
      cycle(16'h0000, 1'b0, 1'b0, 1'b0);
    end
    cycle(16'h0000, 1'b1, 1'b0, 1'b0);
    check_eq("miss3_data",   32'(snap_data),   32'h0001);
    check_eq("miss3_missed", 32'(snap_missed), 32'd2);

    // Miss counter saturation
    cycle(16'h0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 301; i++) begin
      cycle(16'h0001, 1'b0, 1'b0, 1'b0);
      cycle(16'h0000, 1'b0, 1'b0, 1'b0);
    end
    cycle(16'h0000, 1'b1, 1'b0, 1'b0);
    check_eq("sat_missed", 32'(snap_missed), 32'd255);

    // Event coincident with capture edge
    cycle(16'h0000, 1'b0, 1'b0, 1'b1);
    cycle(16'h8000, 1'b1, 1'b0, 1'b0);
    check_eq("coinc_bit15", 32'(snap_data[15]), 32'd1);
    check_eq("coinc_pend",  32'(any_pending),   32'd0);

    // Held level for five cycles
    cycle(16'h0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(16'h0002, 1'b0, 1'b0, 1'b0);
    cycle(16'h0000, 1'b1, 1'b0, 1'b0);
`ifdef TRIG_EDGE_DETECT_EN
    check_eq("level_missed", 32'(snap_missed), 32'd0);
`else
    check_eq("level_missed", 32'(snap_missed), 32'd4);
`endif
    check_eq("level_data", 32'(snap_data), 32'h0002);

    // Reset while holding discards the snapshot; no ack needed afterward
    cycle(16'h0000, 1'b0, 1'b0, 1'b1);
    check_eq("rst_hold_valid", 32'(snap_valid), 32'd0);
    cycle(16'h0020, 1'b1, 1'b0, 1'b0);
    check_eq("post_rst_cap_valid", 32'(snap_valid), 32'd1);
    check_eq("post_rst_cap_data",  32'(snap_data),  32'h0020);

    // Randomized traffic against the model
    cycle(16'h0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      logic [WIDTH-1:0] t;
      t = WIDTH'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) t = '0;
      cycle(t, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
